// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared defaults and queue-entry type for the branch
//               predictor / resolver pair.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

  // Default global-history width; must match the predictor GHR.
  localparam int BP_GHR_W = 3;

  // Default number of in-flight branches tracked by the resolver.
  localparam int BP_DEPTH = 4;

  // One in-flight prediction: predicted direction plus the history that
  // indexed the PHT when the prediction was made.
  typedef struct packed {
    logic                taken;
    logic [BP_GHR_W-1:0] ghr;
  } bp_entry_t;

endpackage : bp_pkg
`default_nettype wire

// File: rtl/bp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bp_fifo
// Description : Synchronous first-word-fall-through queue with a flush input.
//               Flush empties the queue and wins over a same-edge push.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_fifo
  import bp_pkg::*;
#(
  parameter int WIDTH = BP_GHR_W + 1,
  parameter int DEPTH = BP_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[head_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state for pointers, count and storage; pointers wrap naturally
  // because DEPTH is a power of two.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[tail_q] = din;
        tail_d        = tail_q + PTR_W'(1);
      end
      if (do_pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count state; cleared by the active-low synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are don't-care while count is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule : bp_fifo
`default_nettype wire

// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolver
// Description : Tracks in-flight branch predictions, compares each against
//               its resolved outcome, drives predictor updates, flags
//               mispredicts with a corrected history and counts them.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolver
  import bp_pkg::*;
#(
  parameter int GHR_W = BP_GHR_W,
  parameter int DEPTH = BP_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pred_valid,
  input  logic                   pred_taken,
  input  logic [GHR_W-1:0]       pred_ghr,
  output logic                   pred_ready,
  input  logic                   res_valid,
  input  logic                   res_taken,
  output logic                   res_ready,
  output logic                   upd_en,
  output logic                   upd_bit,
  output logic                   mispredict,
  output logic [GHR_W-1:0]       restore_ghr,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [7:0]             mispred_cnt
);

  logic             full;
  logic             empty;
  logic [GHR_W:0]   head_entry;
  logic             head_taken;
  logic [GHR_W-1:0] head_ghr;
  logic             push;
  logic             pop;
  logic             wrong;

  logic             upd_en_q, upd_en_d;
  logic             upd_bit_q, upd_bit_d;
  logic             mispredict_q, mispredict_d;
  logic [GHR_W-1:0] restore_ghr_q, restore_ghr_d;
  logic [7:0]       mispred_cnt_q, mispred_cnt_d;

  assign pred_ready = !full;
  assign res_ready  = !empty;
  assign push       = pred_valid && pred_ready;
  assign pop        = res_valid && res_ready;
  assign head_taken = head_entry[GHR_W];
  assign head_ghr   = head_entry[GHR_W-1:0];
  // A wrong resolution flushes the queue on the same edge, so any push
  // arriving alongside it belongs to the wrong path and is dropped.
  assign wrong      = pop && (res_taken != head_taken);

  bp_fifo #(
    .WIDTH (GHR_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (wrong),
    .push  (push),
    .din   ({pred_taken, pred_ghr}),
    .pop   (pop),
    .dout  (head_entry),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  // Outcome pulses for the cycle after a pop, corrected history and the
  // saturating mispredict counter.
  always_comb begin
    upd_en_d      = pop;
    upd_bit_d     = pop ? res_taken : upd_bit_q;
    mispredict_d  = wrong;
    restore_ghr_d = restore_ghr_q;
    if (pop) begin
      restore_ghr_d = (head_ghr << 1) | GHR_W'(res_taken);
    end
    mispred_cnt_d = mispred_cnt_q;
    if (wrong && (mispred_cnt_q != 8'hFF)) begin
      mispred_cnt_d = mispred_cnt_q + 8'd1;
    end
  end

  // Registered outputs, cleared by the active-low synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      upd_en_q      <= 1'b0;
      upd_bit_q     <= 1'b0;
      mispredict_q  <= 1'b0;
      restore_ghr_q <= '0;
      mispred_cnt_q <= '0;
    end else begin
      upd_en_q      <= upd_en_d;
      upd_bit_q     <= upd_bit_d;
      mispredict_q  <= mispredict_d;
      restore_ghr_q <= restore_ghr_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign upd_en      = upd_en_q;
  assign upd_bit     = upd_bit_q;
  assign mispredict  = mispredict_q;
  assign restore_ghr = restore_ghr_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule : branch_resolver
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolver
// Description : Directed self-checking bench for branch_resolver.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_branch_resolver;

  logic       clk = 1'b0;
  logic       reset;
  logic       pred_valid;
  logic       pred_taken;
  logic [2:0] pred_ghr;
  logic       pred_ready;
  logic       res_valid;
  logic       res_taken;
  logic       res_ready;
  logic       upd_en;
  logic       upd_bit;
  logic       mispredict;
  logic [2:0] restore_ghr;
  logic [2:0] occupancy;
  logic [7:0] mispred_cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  branch_resolver #(
    .GHR_W (3),
    .DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pred_valid  (pred_valid),
    .pred_taken  (pred_taken),
    .pred_ghr    (pred_ghr),
    .pred_ready  (pred_ready),
    .res_valid   (res_valid),
    .res_taken   (res_taken),
    .res_ready   (res_ready),
    .upd_en      (upd_en),
    .upd_bit     (upd_bit),
    .mispredict  (mispredict),
    .restore_ghr (restore_ghr),
    .occupancy   (occupancy),
    .mispred_cnt (mispred_cnt)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic t, input logic [2:0] g);
    pred_valid = 1'b1; pred_taken = t; pred_ghr = g; res_valid = 1'b0;
    step();
    pred_valid = 1'b0;
  endtask

  task automatic pop1(input logic t);
    res_valid = 1'b1; res_taken = t; pred_valid = 1'b0;
    step();
    res_valid = 1'b0;
  endtask

  initial begin
    int exp_cnt;
    reset = 1'b0; pred_valid = 1'b0; pred_taken = 1'b0; pred_ghr = 3'd0;
    res_valid = 1'b0; res_taken = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    check("rst_occ",       occupancy,   0);
    check("rst_pred_rdy",  pred_ready,  1);
    check("rst_res_rdy",   res_ready,   0);
    check("rst_upd_en",    upd_en,      0);
    check("rst_mispred",   mispredict,  0);
    check("rst_cnt",       mispred_cnt, 0);

    // Fill the queue, then try a 5th push which must be refused.
    for (int i = 0; i < 4; i++) push1(1'b1, 3'(i));
    check("full_pred_rdy", pred_ready, 0);
    check("full_occ",      occupancy,  4);
    push1(1'b0, 3'b111);
    check("fifth_occ",     occupancy,  4);
    // Drain with correct resolutions; back-to-back pops pulse every cycle.
    res_valid = 1'b1; res_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain_upd_en",  upd_en,     1);
      check("drain_upd_bit", upd_bit,    1);
      check("drain_mispred", mispredict, 0);
    end
    res_valid = 1'b0;
    step();
    check("drain_res_rdy", res_ready, 0);
    check("idle_upd_en",   upd_en,    0);

    // Single correct resolution.
    push1(1'b1, 3'b010);
    pop1(1'b1);
    check("ok_upd_en",  upd_en,     1);
    check("ok_upd_bit", upd_bit,    1);
    check("ok_mispred", mispredict, 0);
    step();
    check("ok_pulse_end", upd_en, 0);

    // Mispredict on oldest of three entries.
    push1(1'b1, 3'b101);
    push1(1'b0, 3'b000);
    push1(1'b1, 3'b111);
    check("three_occ", occupancy, 3);
    pop1(1'b0);
    check("mp_mispred", mispredict,  1);
    check("mp_upd_en",  upd_en,      1);
    check("mp_upd_bit", upd_bit,     0);
    check("mp_restore", restore_ghr, 3'b010);
    check("mp_occ",     occupancy,   0);
    check("mp_cnt",     mispred_cnt, 1);
    check("mp_res_rdy", res_ready,   0);

    // res_valid while empty is ignored.
    pop1(1'b1);
    check("empty_upd_en",  upd_en,      0);
    check("empty_mispred", mispredict,  0);
    check("empty_occ",     occupancy,   0);
    check("empty_restore", restore_ghr, 3'b010);
    check("empty_cnt",     mispred_cnt, 1);

    // Simultaneous push with correct pop at occupancy 2.
    push1(1'b1, 3'b001);
    push1(1'b1, 3'b011);
    check("two_occ", occupancy, 2);
    pred_valid = 1'b1; pred_taken = 1'b1; pred_ghr = 3'b110;
    res_valid = 1'b1; res_taken = 1'b1;
    step();
    check("pp_ok_occ",     occupancy,  2);
    check("pp_ok_upd_en",  upd_en,     1);
    check("pp_ok_mispred", mispredict, 0);
    // Simultaneous push with mispredicting pop: head is {1,011}.
    pred_valid = 1'b1; pred_taken = 1'b0; pred_ghr = 3'b100;
    res_valid = 1'b1; res_taken = 1'b0;
    step();
    pred_valid = 1'b0; res_valid = 1'b0;
    check("pp_mp_occ",     occupancy,   0);
    check("pp_mp_mispred", mispredict,  1);
    check("pp_mp_restore", restore_ghr, 3'b110);
    check("pp_mp_cnt",     mispred_cnt, 2);
    step();
    check("pp_mp_dropped", res_ready,  0);
    check("pp_mp_end",     mispredict, 0);

    // Force 300 more mispredicts; counter saturates at 255.
    exp_cnt = 2;
    for (int i = 0; i < 300; i++) begin
      push1(1'b1, 3'b011);
      pop1(1'b0);
      if (exp_cnt < 255) exp_cnt++;
      check("sat_cnt", mispred_cnt, exp_cnt);
    end
    check("sat_final", mispred_cnt, 255);

    // Leave an entry in flight and nonzero outputs, then reset mid-traffic.
    push1(1'b1, 3'b011);
    push1(1'b1, 3'b001);
    pop1(1'b1);
    check("pre_rst_upd_bit", upd_bit,     1);
    check("pre_rst_occ",     occupancy,   1);
    reset = 1'b0;
    pred_valid = 1'b1; pred_taken = 1'b0; pred_ghr = 3'b111;
    res_valid = 1'b1; res_taken = 1'b0;
    step();
    reset = 1'b1; pred_valid = 1'b0; res_valid = 1'b0;
    check("r2_occ",       occupancy,   0);
    check("r2_res_rdy",   res_ready,   0);
    check("r2_pred_rdy",  pred_ready,  1);
    check("r2_upd_en",    upd_en,      0);
    check("r2_upd_bit",   upd_bit,     0);
    check("r2_mispred",   mispredict,  0);
    check("r2_restore",   restore_ghr, 0);
    check("r2_cnt",       mispred_cnt, 0);
    step();
    check("r2_hold_occ",  occupancy,   0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_branch_resolver
`default_nettype wire

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter GHR_W, default 3, meaning global-history width; it SHALL match the predictor GHR width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning in-flight branch queue entries; it SHALL be a power of two and at least 2.
REQ-003 SHALL have port clk  input  1  meaning sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  meaning synchronous, active-low reset; 0 at a rising clk edge resets the block.
REQ-005 SHALL have port pred_valid  input  1  meaning predictor presents a new in-flight prediction.
REQ-006 SHALL have port pred_taken  input  1  meaning predicted direction (predictor pred bit).
REQ-007 SHALL have port pred_ghr  input  GHR_W  meaning GHR value that indexed the PHT for this prediction.
REQ-008 SHALL have port pred_ready  output  1  meaning queue can accept a prediction; equals !full.
REQ-009 SHALL have port res_valid  input  1  meaning execute stage presents the outcome of the oldest unresolved branch.
REQ-010 SHALL have port res_taken  input  1  meaning actual branch direction.
REQ-011 SHALL have port res_ready  output  1  meaning an entry is waiting for resolution; equals !empty.
REQ-012 SHALL have port upd_en  output  1  meaning one-cycle pulse to the predictor update_en.
REQ-013 SHALL have port upd_bit  output  1  meaning actual outcome for the predictor in_bit.
REQ-014 SHALL have port mispredict  output  1  meaning one-cycle pulse on a wrong prediction.
REQ-015 SHALL have port restore_ghr  output  GHR_W  meaning corrected history {snapshot[GHR_W-2:0], actual}; valid while mispredict=1.
REQ-016 SHALL have port occupancy  output  clog2(DEPTH)+1  meaning current queue entries.
REQ-017 SHALL have port mispred_cnt  output  8  meaning saturating mispredict count.

Function
REQ-018 A push SHALL occur on a rising edge with pred_valid=1 and pred_ready=1; it stores {pred_taken, pred_ghr} at the tail.
REQ-019 A pop SHALL occur on a rising edge with res_valid=1 and res_ready=1; it compares res_taken with the head pred_taken.
REQ-020 Latency SHALL be one cycle: the cycle after a pop, upd_en=1, upd_bit=res_taken, and mispredict=(res_taken != head pred_taken).
REQ-021 restore_ghr SHALL be registered with mispredict and hold its value until the next pop.
REQ-022 A mispredicting pop SHALL flush the queue, giving occupancy=0 after the edge; a push on the same edge SHALL be discarded as wrong-path.
REQ-023 A correctly predicted pop with a simultaneous push SHALL leave occupancy unchanged.
REQ-024 A push SHALL NOT occur when full, and a pop SHALL NOT occur when empty; res_valid while empty SHALL be ignored with no pulse.
REQ-025 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-026 mispred_cnt SHALL increment by 1 per mispredict and saturate at 255.
REQ-027 upd_en and mispredict SHALL be 0 in every cycle not following a pop.

Reset
REQ-028 With reset=0 at an edge, the block SHALL clear occupancy, pointers, upd_en, upd_bit, mispredict, restore_ghr and mispred_cnt to 0.
REQ-029 Reset SHALL override any simultaneous push or pop; a reset mid-operation SHALL discard all in-flight entries.
REQ-030 After reset, pred_ready SHALL be 1 and res_ready SHALL be 0.

Structure
REQ-031 Package bp_pkg SHALL hold GHR_W and DEPTH defaults and the queue-entry type {taken, ghr}, shared with branch_predictor.
REQ-032 The queue SHALL be one sub-module, bp_fifo (sync, first-word fall-through head, flush input); compare and counter logic stays in branch_resolver.

Verification
REQ-033 The bench SHALL cover: after reset, push 4 entries -> pred_ready=0 and occupancy=4; a 5th pred_valid is not stored.
REQ-034 The bench SHALL cover: push {taken=1, ghr=3'b010}, then resolve res_taken=1 -> next cycle upd_en=1, upd_bit=1, mispredict=0.
REQ-035 The bench SHALL cover: push {taken=1, ghr=3'b101} plus 2 more, then resolve res_taken=0 -> mispredict=1, restore_ghr=3'b010, occupancy=0, mispred_cnt=1.
REQ-036 The bench SHALL cover: res_valid=1 while empty -> no upd_en, mispredict or occupancy change.
REQ-037 The bench SHALL cover: at occupancy 2, a simultaneous push and correct pop -> occupancy stays 2; with a mispredicting pop instead -> occupancy=0.
REQ-038 The bench SHALL cover: 300 forced mispredicts -> mispred_cnt=255; then reset=0 for one edge -> all outputs 0 and res_ready=0.
